// File: rtl/spart_pkg.sv
// Shared definitions for the SPART: register map, status bit positions,
// the serial FSM state encoding and standard baud divisors (50 MHz, x16).
package spart_pkg;

  // Register select values on ioaddr
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  // Bit positions inside the status byte
  localparam int RDA_BIT = 0;
  localparam int TBR_BIT = 1;

  // Both serial engines walk the same frame shape
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

  // Divisors for 16x oversampling at 50 MHz
  localparam logic [15:0] DIV_4800  = 16'h028A;
  localparam logic [15:0] DIV_9600  = 16'h0145;
  localparam logic [15:0] DIV_19200 = 16'h00A2;
  localparam logic [15:0] DIV_38400 = 16'h0050;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud enable generator: a 16-bit down-counter that pulses
// en_o for one clock when it reaches zero, then reloads the divisor.
// Enable period is divisor+1 clocks; divisor 0 pulses every cycle.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] RESET_DIVISOR = DIV_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_lo_i,
  input  logic       wr_hi_i,
  input  logic [7:0] data_i,
  output logic       en_o
);

  logic [15:0] divisor_q, divisor_d;
  logic [15:0] cnt_q, cnt_d;

  assign en_o = (cnt_q == 16'd0);

  // Next divisor from byte writes; a write restarts the count with the new value
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    divisor_d = divisor_q;
    if (wr_lo_i) divisor_d[7:0]  = data_i;
    if (wr_hi_i) divisor_d[15:8] = data_i;

    if (wr_lo_i || wr_hi_i) cnt_d = divisor_d;
    else if (en_o)          cnt_d = divisor_q;
    else                    cnt_d = cnt_q - 16'd1;
  end

  // Divisor and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor_q <= RESET_DIVISOR;
      cnt_q     <= RESET_DIVISOR;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/spart.sv
// SPART: bus slave behind the driver FSM. Decodes iocs/iorw/ioaddr cycles,
// owns the baud generator and the 8N1 transmitter and receiver.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] RESET_DIVISOR = DIV_19200,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  // ---------------------------------------------------------------- bus decode
  logic       rd_cyc, wr_cyc;
  logic       rd_data_cyc, tx_wr;
  logic       drive_en;
  logic [7:0] rd_data, status;
  logic       baud_en;

  // TX state
  ser_state_e tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic       txd_q, txd_d;

  // RX state
  ser_state_e             rx_state_q, rx_state_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [3:0]             rx_tick_q, rx_tick_d;
  logic [7:0]             rx_buf_q, rx_buf_d;
  logic                   rda_q, rda_d;
  logic                   rx_done;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  assign rd_cyc      = iocs & iorw;
  assign wr_cyc      = iocs & ~iorw;
  assign rd_data_cyc = rd_cyc & (ioaddr == ADDR_DATA);
  assign tx_wr       = wr_cyc & (ioaddr == ADDR_DATA) & tbr;
  assign drive_en    = rd_cyc & ((ioaddr == ADDR_DATA) | (ioaddr == ADDR_STATUS));

  assign tbr = (tx_state_q == IDLE);
  assign rda = rda_q;
  assign txd = txd_q;

  // Read mux: rx buffer or status byte
  always_comb begin
    status          = '0;
    status[RDA_BIT] = rda_q;
    status[TBR_BIT] = tbr;
    rd_data         = (ioaddr == ADDR_STATUS) ? status : rx_buf_q;
  end

  assign databus = drive_en ? rd_data : 8'hzz;

  spart_baud_gen #(
    .RESET_DIVISOR(RESET_DIVISOR)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .wr_lo_i (wr_cyc & (ioaddr == ADDR_DB_LO)),
    .wr_hi_i (wr_cyc & (ioaddr == ADDR_DB_HI)),
    .data_i  (databus),
    .en_o    (baud_en)
  );

  // ---------------------------------------------------------------- transmitter
  // TX next state: start bit waits for the next enable (txd still high marks
  // "not yet started"), then every bit holds for 16 enables.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_tick_d  = tx_tick_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      IDLE: begin
        if (tx_wr) begin
          tx_shift_d = databus;
          tx_tick_d  = 4'd0;
          tx_state_d = START;
        end
      end
      START: begin
        if (baud_en) begin
          if (txd_q) begin
            txd_d     = 1'b0;
            tx_tick_d = 4'd0;
          end else if (tx_tick_q == 4'd15) begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = 3'd0;
            tx_tick_d  = 4'd0;
            tx_state_d = DATA;
          end else begin
            tx_tick_d = tx_tick_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (baud_en) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              txd_d      = 1'b1;
              tx_state_d = STOP;
            end else begin
              txd_d      = tx_shift_q[0];
              tx_shift_d = tx_shift_q >> 1;
              tx_bit_d   = tx_bit_q + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (baud_en) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // TX registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= IDLE;
      tx_shift_q <= 8'h00;
      tx_bit_q   <= 3'd0;
      tx_tick_q  <= 4'd0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_tick_q  <= tx_tick_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------------------------------------------------------- receiver
  assign rx_s = sync_q[SYNC_STAGES-1];

  // rxd synchroniser; idles high so reset does not fake a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  // RX next state: mid-bit check of the start bit, then sample every 16 enables
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_tick_d  = rx_tick_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        if (!rx_s) begin
          rx_tick_d  = 4'd0;
          rx_state_d = START;
        end
      end
      START: begin
        if (baud_en) begin
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s ? IDLE : DATA;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (baud_en) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_en) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_done    = rx_s;
            rx_state_d = IDLE;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Buffer and rda: a completed byte wins over a same-cycle data read
  always_comb begin
    rx_buf_d = rx_done ? rx_shift_q : rx_buf_q;
    if (rx_done)          rda_d = 1'b1;
    else if (rd_data_cyc) rda_d = 1'b0;
    else                  rda_d = rda_q;
  end

  // RX registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= IDLE;
      rx_shift_q <= 8'h00;
      rx_bit_q   <= 3'd0;
      rx_tick_q  <= 4'd0;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_tick_q  <= rx_tick_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
    end
  end

endmodule

// File: tb/tb_spart.sv
// Testbench for spart: bus reads and txd frames are checked by monitors
// against expectations queued by the stimulus.
module tb_spart;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] tb_db = 8'h00;
  logic       tb_drv = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  wire  [7:0] databus;
  wire        rxd;
  logic       rda, tbr, txd;

  assign databus = tb_drv ? tb_db : 8'hzz;
  assign rxd     = loop_en ? txd : rxd_drv;

  spart dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    int         bit_clks;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  logic [7:0] rd_val_q[$];
  string      rd_name_q[$];
  bit         tx_mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- bus tasks
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_db = d; tb_drv = 1'b1;
    @(posedge clk); #1;
    iocs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input string nm, input logic [7:0] exp);
    rd_val_q.push_back(exp);
    rd_name_q.push_back(nm);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic wait_rda(input string nm, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rda) break;
    end
    check(nm, rda, 1'b1);
  endtask

  task automatic wait_tbr(input string nm, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tbr) break;
    end
    check(nm, tbr, 1'b1);
  endtask

  task automatic measure_en(input string nm, input int exp);
    int c;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dut.u_baud.en_o) break;
    end
    c = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (dut.u_baud.en_o) begin
        c = i;
        break;
      end
    end
    check(nm, c, exp);
  endtask

  task automatic send(input logic [7:0] d, input int bc);
    tx_exp_t e;
    e.data = d;
    e.bit_clks = bc;
    tx_q.push_back(e);
    bus_wr(ADDR_DATA, d);
  endtask

  // Bench-driven 8N1 frame on rxd; a bad stop bit is held low for 11/16 bit
  task automatic drive_frame(input logic [7:0] d, input bit bad_stop, input int bc);
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (bc) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (bc) @(posedge clk);
      #1;
    end
    if (bad_stop) begin
      rxd_drv = 1'b0;
      repeat (bc * 11 / 16) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (bc) @(posedge clk);
  endtask

  // ---------------------------------------------------------------- read monitor
  always @(negedge clk) begin
    if (iocs && iorw && (ioaddr == ADDR_DATA || ioaddr == ADDR_STATUS)) begin
      if (rd_val_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: read of addr %0d with nothing queued, bus %0h", ioaddr, databus);
      end else begin
        check(rd_name_q.pop_front(), databus, rd_val_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- txd monitor
  initial begin : tx_mon
    logic       prev;
    tx_exp_t    e;
    logic [9:0] samp;
    int         first_chg;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev && !txd) begin
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: txd frame started, none queued");
        end else begin
          e = tx_q.pop_front();
          first_chg = 0;
          samp = '0;
          for (int t = 0; t <= 9 * e.bit_clks + e.bit_clks / 2; t++) begin
            if (t > 0) @(negedge clk);
            if (first_chg == 0 && txd !== 1'b0) first_chg = t;
            if (t % e.bit_clks == e.bit_clks / 2) samp[t / e.bit_clks] = txd;
          end
          check("tx_start_bit", samp[0], 1'b0);
          check("tx_data", samp[8:1], e.data);
          check("tx_stop_bit", samp[9], 1'b1);
          if (e.data[0]) check("tx_bit_clks", first_chg, e.bit_clks);
        end
      end
      prev = txd;
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] div_fast;
    div_fast = DIV_38400;

    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1'b1);
    check("reset_tbr", tbr, 1'b1);
    check("reset_rda", rda, 1'b0);
    rst = 1'b1;

    bus_rd(ADDR_STATUS, "status_reset", 8'h02);
    measure_en("en_period_reset", 163);

    // 0x55 at reset divisor, looped back
    loop_en = 1'b1;
    send(8'h55, 2608);
    check("tbr_low_after_wr_55", tbr, 1'b0);
    wait_rda("rda_55", 30000);
    bus_rd(ADDR_DATA, "rx_55", 8'h55);
    check("rda_clr_55", rda, 1'b0);
    wait_tbr("tbr_55", 5000);

    // 38400 divisor
    bus_wr(ADDR_DB_LO, div_fast[7:0]);
    bus_wr(ADDR_DB_HI, div_fast[15:8]);
    measure_en("en_period_38400", 81);

    send(8'hA7, 1296);
    wait_rda("rda_A7", 15000);
    bus_rd(ADDR_DATA, "rx_A7", 8'hA7);
    check("rda_clr_A7", rda, 1'b0);
    wait_tbr("tbr_A7", 3000);

    send(8'hC3, 1296);
    wait_rda("rda_C3", 15000);
    bus_rd(ADDR_DATA, "rx_C3", 8'hC3);
    wait_tbr("tbr_C3", 3000);

    // Fast divisor for the remaining tests: 4 clocks per enable, 64 per bit
    bus_wr(ADDR_DB_LO, 8'h03);

    // Write while busy is ignored
    send(8'h3C, 64);
    check("tbr_low_after_wr_3C", tbr, 1'b0);
    bus_wr(ADDR_DATA, 8'hFF);
    wait_rda("rda_3C", 1000);
    bus_rd(ADDR_DATA, "rx_3C", 8'h3C);
    wait_tbr("tbr_3C", 1000);
    repeat (300) @(posedge clk);
    bus_rd(ADDR_STATUS, "status_no_second_byte", 8'h02);

    // Glitch on rxd: low for 3 enables only
    loop_en = 1'b0;
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (200) @(posedge clk);
    bus_rd(ADDR_STATUS, "status_glitch", 8'h02);

    // Framing error: byte discarded, buffer keeps 0x3C
    drive_frame(8'h96, 1'b1, 64);
    repeat (200) @(posedge clk);
    bus_rd(ADDR_STATUS, "status_framing", 8'h02);
    bus_rd(ADDR_DATA, "rx_keep_after_framing", 8'h3C);

    // Good bench-driven frame left unread
    drive_frame(8'h96, 1'b0, 64);
    wait_rda("rda_96", 200);
    bus_rd(ADDR_STATUS, "status_rda_set", 8'h03);

    // Reset in the middle of a transmit
    tx_mon_en = 1'b0;
    bus_wr(ADDR_DATA, 8'h00);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!txd) break;
    end
    check("txd_start_before_rst", txd, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_tbr", tbr, 1'b1);
    check("rst_rda", rda, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus_rd(ADDR_DATA, "rx_buf_after_rst", 8'h00);
    bus_rd(ADDR_STATUS, "status_after_rst", 8'h02);
    measure_en("en_period_after_rst", 163);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spart.md
Name: spart

Overview:
- Special-purpose async receiver/transmitter; the bus slave directly downstream of the driver FSM.
- Decodes the driver's iocs/iorw/ioaddr/databus cycles.
- Holds a 16-bit programmable baud divisor and serialises/deserialises 8N1 frames on txd/rxd.
- Reports rda/tbr back to the driver.

Parameters:
RESET_DIVISOR, 16'h00A2, divisor loaded at reset (19200 baud x16 at 50 MHz).
SYNC_STAGES, 2, flop stages on rxd before use (min 2).

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-low reset.
iocs  input  1  chip select; no bus effect when low.
iorw  input  1  1 = read, 0 = write.
ioaddr  input  2  register select.
databus  inout  8  bidirectional data bus.
rda  output  1  receive data available.
tbr  output  1  transmit buffer ready.
txd  output  1  serial out, idle high.
rxd  input  1  serial in, asynchronous.

Behaviour:
- Reset is asynchronous, active-low, on clk domain.
  - Reset values: txd=1, tbr=1, rda=0, databus released (Z), divisor=RESET_DIVISOR, rx buffer=8'h00.
  - Both TX and RX FSMs return to IDLE immediately; a frame in flight is abandoned and txd goes high.
- Register map; all accesses are single-cycle with iocs=1.
  - ioaddr 00, read: databus = rx buffer, combinational in the same cycle. rda clears on the next edge.
  - ioaddr 00, write: if tbr=1, latch databus into the tx shift register. tbr=0 from the next edge. Write while tbr=0 is ignored.
  - ioaddr 01, read: databus = {6'b0, tbr, rda}. ioaddr 01, write: ignored.
  - ioaddr 10, write: divisor[7:0] <= databus. ioaddr 11, write: divisor[15:8] <= databus.
  - Reads of 10/11 leave databus at Z.
- databus is driven only when iocs & iorw & (ioaddr==00 | ioaddr==01); it is Z otherwise.
- Baud generator:
  - 16-bit down-counter produces a one-cycle enable when it reaches 0, then reloads divisor; enable period = divisor+1 clocks.
  - Any divisor-byte write reloads the counter with the updated full divisor on the next edge.
  - Divisor 0 gives an enable every cycle.
  - Reference values: 4800 = 0x028A, 9600 = 0x0145, 19200 = 0x00A2, 38400 = 0x0050.
- Transmitter (states IDLE, START, DATA, STOP):
  - Each bit lasts 16 enables.
  - Frame: start 0, data[0..7] LSB first, stop 1; 3-bit bit counter and 4-bit tick counter.
  - Write accepted in IDLE moves to START on the next edge; the start bit is aligned to the next enable.
  - tbr returns to 1 the cycle after the 16th stop-bit enable; a new write may follow immediately.
- Receiver (states IDLE, START, DATA, STOP):
  - rxd passes through SYNC_STAGES flops.
  - IDLE->START on synchronised rxd==0.
  - START: on the 8th enable (mid-bit) rxd must still be 0, else back to IDLE (glitch reject). If 0, reset the tick counter.
  - DATA: sample at every 16th enable, shift in LSB first, 8 bits.
  - STOP: sample at the 16th enable.
    - Stop=1: rx buffer <= shifted byte, rda <= 1.
    - Stop=0 (framing error): discard the byte, rda unchanged.
    - Either way return to IDLE.
  - A new byte overwrites an unread rx buffer (overrun, no flag).
  - Byte completion and a 00 read in the same cycle: the read returns the old byte; set wins, so rda=1 with the new byte.
- Divisor change mid-frame: takes effect from the next enable; the current frame is not aborted.

Decomposition:
- Package spart_pkg:
  - ioaddr constants ADDR_DATA=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LO=2'b10, ADDR_DB_HI=2'b11.
  - Status bit indices RDA_BIT=0, TBR_BIT=1.
  - Shared serial FSM enum {IDLE, START, DATA, STOP}.
  - Standard divisor constants for the four baud rates.
- One sub-module, spart_baud_gen: divisor registers, down-counter, reload-on-write, en output.
- TX and RX stay in spart.

Test Plan:
- Reset, status read (ioaddr 01, iorw 1) -> databus=8'h02, txd=1, no enable until counter runs; enable period measured as 163 clks.
- Write 8'h55 to 00 at divisor 0x00A2 -> tbr=0 next cycle; txd shows 0,1,0,1,0,1,0,1,0,1 at 2608 clks per bit (16x163); tbr=1 after stop bit.
- Loop txd->rxd, send 8'hA7 -> rda=1 after stop; 00 read returns 8'hA7, rda=0 next cycle.
- Write DB lo 8'h50, DB hi 8'h00, send 8'hC3 looped -> bit time 1296 clks; received 8'hC3.
- Drive rxd low for 3 enables then high -> no rda. Frame with stop=0 -> rda stays 0, buffer unchanged.
- Second write while tbr=0 -> ignored, original byte transmitted. rst pulse mid-transmit -> txd=1, tbr=1 immediately.
